// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RISC-V pipeline: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register that feeds the memory stage.
module execute_cycle #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWrite_E,
    input  logic            MemWrite_E,
    input  logic            ALUSrc_E,
    input  logic            Branch_E,
    input  logic            Jump_E,
    input  logic [1:0]      ResultSrc_E,
    input  logic [2:0]      ALUControl_E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic [XLEN-1:0] PCPlus4_E,
    input  logic [XLEN-1:0] ImmExt_E,
    input  logic [4:0]      Rd_E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic            FlushM,
    output logic            PCSrc_E,
    output logic [XLEN-1:0] PCTarget_E,
    output logic            RegWrite_M,
    output logic            MemWrite_M,
    output logic [1:0]      ResultSrc_M,
    output logic [XLEN-1:0] ALUResult_M,
    output logic [XLEN-1:0] WriteData_M,
    output logic [XLEN-1:0] PCPlus4_M,
    output logic [4:0]      Rd_M
);

    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] fwdB;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] aluResult;
    logic            zero;

    // Select 11 is reserved and falls back to the register-file operand.
    always_comb begin
        srcA = RD1_E;
        case (ForwardA_E)
            2'b01:   srcA = ResultW;
            2'b10:   srcA = ALUResult_M;
            default: srcA = RD1_E;
        endcase

        fwdB = RD2_E;
        case (ForwardB_E)
            2'b01:   fwdB = ResultW;
            2'b10:   fwdB = ALUResult_M;
            default: fwdB = RD2_E;
        endcase

        srcB = ALUSrc_E ? ImmExt_E : fwdB;
    end

    always_comb begin
        aluResult = '0;
        case (ALUControl_E)
            3'b000:  aluResult = srcA + srcB;
            3'b001:  aluResult = srcA + (~srcB) + {{(XLEN-1){1'b0}}, 1'b1};
            3'b010:  aluResult = srcA & srcB;
            3'b011:  aluResult = srcA | srcB;
            3'b101:  aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            default: aluResult = '0;
        endcase
        zero = (aluResult == '0);
    end

    assign PCSrc_E    = Jump_E | (Branch_E & zero);
    assign PCTarget_E = PC_E + ImmExt_E;

    // A flush only kills the side-effecting controls; the data fields are don't-care.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            ResultSrc_M <= '0;
            ALUResult_M <= '0;
            WriteData_M <= '0;
            PCPlus4_M   <= '0;
            Rd_M        <= '0;
        end else begin
            RegWrite_M  <= RegWrite_E & ~FlushM;
            MemWrite_M  <= MemWrite_E & ~FlushM;
            ResultSrc_M <= ResultSrc_E;
            ALUResult_M <= aluResult;
            WriteData_M <= fwdB;
            PCPlus4_M   <= PCPlus4_E;
            Rd_M        <= Rd_E;
        end
    end

endmodule
